// File: rtl/npc_mem_pkg.sv
// Shared definitions for the NPC start/done memory-latency handshake:
// request size encodings, initiator FSM states, LFSR constants and the
// default timeout, plus the request legality check.
package npc_mem_pkg;

   localparam logic [1:0] SZ_B   = 2'd0;
   localparam logic [1:0] SZ_H   = 2'd1;
   localparam logic [1:0] SZ_W   = 2'd2;
   localparam logic [1:0] SZ_RSV = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Fibonacci taps 16,14,13,11 expressed as a mask over lfsr[15:0].
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam int DEF_TIMEOUT = 64;

   // A request is rejected locally when its size is reserved or its
   // address is not naturally aligned for that size.
   function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lo);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = lo[0];
         SZ_W:    bad = (lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_req_initiator_lat_lfsr.sv
// lat_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11) that steps once per
// asserted adv and exposes its low three bits as a latency selector.
// Only instantiated by mem_req_initiator when MEM_REQ_RAND_LAT_EN is defined.
module lat_lfsr
   import npc_mem_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       adv,
   output logic [2:0] lat
);

   logic [15:0] lfsr;
   logic        fb;

   assign fb  = ^(lfsr & LFSR_TAPS);
   assign lat = lfsr[2:0];

   // Shift register: reseed on reset, step when the initiator issues.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= LFSR_SEED;
      end else if (adv) begin
         lfsr <= {lfsr[14:0], fb};
      end
   end

endmodule

// File: rtl/mem_req_initiator.sv
// mem_req_initiator: initiator side of the NPC start/done memory-latency
// handshake. Accepts one request, pulses mem_start with a latency code,
// waits for mem_done or a timeout and returns one response. One transaction
// outstanding at a time.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1; a valid side holds valid and its payload stable until that
// edge, and ready never depends on valid of the same port.
//
// Build option: define MEM_REQ_RAND_LAT_EN to draw mem_times from an LFSR
// (range 1..8) instead of the LATENCY constant.
module mem_req_initiator
   import npc_mem_pkg::*;
#(
   parameter int         AW      = 32,
   parameter int         DW      = 32,
   parameter logic [4:0] LATENCY = 5'd1,
   parameter int         TIMEOUT = DEF_TIMEOUT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_wen,
   input  logic [1:0]    req_size,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   input  logic [3:0]    req_wmask,
   output logic          resp_valid,
   input  logic          resp_ready,
   output logic [DW-1:0] resp_rdata,
   output logic          resp_err,
   output logic          mem_start,
   output logic [4:0]    mem_times,
   output logic          mem_wen,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic [3:0]    mem_wmask,
   input  logic          mem_done,
   input  logic [DW-1:0] mem_rdata,
   output state_t        state_dbg
);

   localparam int             CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   logic          timed_out;
   logic          bad_req;
   logic [4:0]    lat_code;

   assign cnt_inc   = cnt + 1'b1;
   assign timed_out = (cnt_inc == CNT_LAST);
   assign bad_req   = req_bad(req_size, req_addr[1:0]);

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign mem_start  = (state == ISSUE);
   assign mem_times  = (state == ISSUE) ? lat_code : 5'd0;
   assign state_dbg  = state;

`ifdef MEM_REQ_RAND_LAT_EN
   logic [2:0] lfsr_lat;

   lat_lfsr u_lat_lfsr (
      .clk (clk),
      .rst (rst),
      .adv (state == ISSUE),
      .lat (lfsr_lat)
   );

   assign lat_code = {2'b00, lfsr_lat} + 5'd1;
`else
   assign lat_code = LATENCY;
`endif

   // State register; reset aborts any transaction without a response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; mem_done only matters in WAIT and beats the timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_valid) state_nxt = bad_req ? RESP : ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (mem_done || timed_out) state_nxt = RESP;
         RESP:    if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch, wait counter and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_wen    <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wmask  <= 4'h0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         cnt        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  mem_wen    <= req_wen;
                  mem_addr   <= req_addr;
                  mem_wdata  <= req_wdata;
                  mem_wmask  <= req_wmask;
                  resp_rdata <= '0;
                  resp_err   <= bad_req;
               end
            end
            ISSUE: begin
               cnt <= '0;
            end
            WAIT: begin
               if (mem_done) begin
                  resp_rdata <= mem_wen ? '0 : mem_rdata;
                  resp_err   <= 1'b0;
               end else if (timed_out) begin
                  resp_rdata <= '0;
                  resp_err   <= 1'b1;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               // RESP: response held until consumed.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_req_initiator.sv
// Directed bench for mem_req_initiator built with TIMEOUT=8. The bench
// plays both the LSU and the delay responder; expected values are written
// out per vector.
module tb_mem_req_initiator;
   import npc_mem_pkg::*;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wen;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wmask;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_start, mem_wen, mem_done;
   logic [4:0]  mem_times, mem_wmask_dummy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;
   logic [1:0]  state_dbg;

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   mem_req_initiator #(.AW(32), .DW(32), .LATENCY(5'd1), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_wmask(req_wmask),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_start(mem_start), .mem_times(mem_times),
      .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask),
      .mem_done(mem_done), .mem_rdata(mem_rdata),
      .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction. done_at: WAIT-cycle index on which the
   // responder raises mem_done (-1 = never). exp_lat: cycles from the accept
   // edge until resp_valid is seen. hold: cycles resp_ready stays low.
   task automatic xact(input string tag, input logic wen, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask, input int done_at,
                       input logic [31:0] rd, input logic exp_err,
                       input logic [31:0] exp_rd, input int exp_lat,
                       input int exp_starts, input int hold);
      int lat, starts, k, bad;
      logic [31:0] exp_v, h_rd;
      logic h_err;
      req_valid = 1'b1; req_wen = wen; req_size = size; req_addr = addr;
      req_wdata = wdata; req_wmask = wmask;
      check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      exp_q.push_back(exp_rd);
      tick();
      req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
      lat = 1; starts = 0; k = -1; bad = 0;
      while (!resp_valid && lat < 40) begin
         mem_done = 1'b0;
         if (mem_start) begin
            starts++;
            k = 0;
`ifdef MEM_REQ_RAND_LAT_EN
            check({tag, "_times_range"}, {31'd0, (mem_times >= 5'd1 && mem_times <= 5'd8)}, 32'd1);
`else
            check({tag, "_times"}, {27'd0, mem_times}, 32'd1);
`endif
            // done during ISSUE must be ignored
            mem_done = 1'b1; mem_rdata = 32'hBAD0_BAD0;
         end else if (k >= 0) begin
            k++;
         end
         if (k >= 1 && (k - 1) == done_at) begin
            mem_done = 1'b1; mem_rdata = rd;
         end
         if (k >= 0 && (mem_wen !== wen || mem_addr !== addr ||
                        mem_wdata !== wdata || mem_wmask !== wmask)) bad++;
         tick();
         lat++;
      end
      mem_done = 1'b0;
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_starts"}, starts, exp_starts);
      check({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
      exp_v = exp_q.pop_front();
      check({tag, "_rdata"}, resp_rdata, exp_v);
      if (exp_starts > 0) check({tag, "_latch_stable"}, bad, 0);
      // response hold: outputs stable, no new request accepted, done ignored
      h_rd = resp_rdata; h_err = resp_err; bad = 0;
      for (int i = 0; i < hold; i++) begin
         mem_done = 1'b1; mem_rdata = 32'h0BAD_F00D;
         req_valid = 1'b1;
         tick();
         if (resp_valid !== 1'b1 || resp_rdata !== h_rd || resp_err !== h_err ||
             req_ready !== 1'b0) bad++;
      end
      mem_done = 1'b0; req_valid = 1'b0;
      if (hold > 0) check({tag, "_hold_stable"}, bad, 0);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check({tag, "_resp_drop"}, {31'd0, resp_valid}, 32'd0);
      check({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'd0;
      req_addr = 32'd0; req_wdata = 32'd0; req_wmask = 4'd0;
      resp_ready = 1'b0; mem_done = 1'b0; mem_rdata = 32'd0;
      mem_wmask_dummy = 5'd0;
      #12;
      check("rst_req_ready",  {31'd0, req_ready},  32'd1);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_err",   {31'd0, resp_err},   32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_mem_start",  {31'd0, mem_start},  32'd0);
      check("rst_mem_times",  {27'd0, mem_times},  32'd0);
      check("rst_mem_addr",   mem_addr, 32'd0);
      check("rst_state",      {30'd0, state_dbg},  32'd0);
      @(negedge clk); rst = 1'b0;
      tick();

      //   tag        wen  size addr          wdata         mask  done  rd            err  exp_rd        lat st hold
      xact("ld_w",    1'b0, SZ_W, 32'h8000_0004, 32'h0, 4'h0, 0,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 3, 1, 0);
      xact("st_w",    1'b1, SZ_W, 32'h8000_0010, 32'h1234_5678, 4'hF, 2, 32'hFFFF_FFFF, 1'b0, 32'h0, 5, 1, 0);
      xact("ld_h_mis",1'b0, SZ_H, 32'h8000_0001, 32'h0, 4'h0, 0,  32'h1111_1111, 1'b1, 32'h0, 1, 0, 0);
      xact("ld_rsv",  1'b0, SZ_RSV, 32'h8000_0000, 32'h0, 4'h0, 0, 32'h2222_2222, 1'b1, 32'h0, 1, 0, 0);
      xact("ld_w_mis",1'b0, SZ_W, 32'h8000_0002, 32'h0, 4'h0, 0,  32'h3333_3333, 1'b1, 32'h0, 1, 0, 0);
      xact("ld_h_ok", 1'b0, SZ_H, 32'h8000_0002, 32'h0, 4'h0, 0,  32'h0000_ABCD, 1'b0, 32'h0000_ABCD, 3, 1, 0);
      xact("st_b",    1'b1, SZ_B, 32'h8000_0003, 32'h5A00_0000, 4'h8, 1, 32'h4444_4444, 1'b0, 32'h0, 4, 1, 0);
      xact("timeout", 1'b0, SZ_W, 32'h8000_0020, 32'h0, 4'h0, -1, 32'h0, 1'b1, 32'h0, TO + 1, 1, 0);
      xact("done_last",1'b0, SZ_W, 32'h8000_0024, 32'h0, 4'h0, TO - 2, 32'h55AA_55AA, 1'b0, 32'h55AA_55AA, TO + 1, 1, 0);
      xact("hold5",   1'b0, SZ_W, 32'h8000_0028, 32'h0, 4'h0, 1,  32'h1357_9BDF, 1'b0, 32'h1357_9BDF, 4, 1, 5);
      xact("b2b_a",   1'b0, SZ_W, 32'h8000_0030, 32'h0, 4'h0, 0,  32'hA5A5_0001, 1'b0, 32'hA5A5_0001, 3, 1, 0);
      xact("b2b_b",   1'b0, SZ_W, 32'h8000_0034, 32'h0, 4'h0, 0,  32'hA5A5_0002, 1'b0, 32'hA5A5_0002, 3, 1, 0);

      // reset during WAIT aborts the transaction
      req_valid = 1'b1; req_wen = 1'b1; req_size = SZ_W; req_addr = 32'h8000_0040;
      req_wdata = 32'hCAFE_F00D; req_wmask = 4'hF;
      tick(); req_valid = 1'b0;
      tick();
      check("mid_in_wait", {30'd0, state_dbg}, 32'd2);
      rst = 1'b1;
      #1;
      check("mid_rst_req_ready",  {31'd0, req_ready},  32'd1);
      check("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("mid_rst_mem_start",  {31'd0, mem_start},  32'd0);
      check("mid_rst_mem_wen",    {31'd0, mem_wen},    32'd0);
      check("mid_rst_mem_addr",   mem_addr,  32'd0);
      check("mid_rst_mem_wdata",  mem_wdata, 32'd0);
      check("mid_rst_mem_wmask",  {28'd0, mem_wmask}, 32'd0);
      @(negedge clk); rst = 1'b0;
      tick();
      xact("post_rst", 1'b0, SZ_W, 32'h8000_0044, 32'h0, 4'h0, 0, 32'h7777_0001, 1'b0, 32'h7777_0001, 3, 1, 0);

      // many requests: latency code always legal
      for (int i = 0; i < 100; i++) begin
         xact("loop", 1'b0, SZ_W, 32'h8000_1000 + 32'(i * 4), 32'h0, 4'h0, 0,
              32'(i) ^ 32'h6000_0000, 1'b0, 32'(i) ^ 32'h6000_0000, 3, 1, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
